seq_mult_dot_driver: RTL and testbench
======================================

# seq_mult_dot_driver

Upstream sequencing stage for the 6-bit unsigned sequential right-shift multiplier. It accepts operand pairs over a valid/ready stream, pulses the multiplier's `load`, waits out the fixed 6-cycle computation, and captures the 13-bit product. Products are accumulated into a dot-product sum, and one result per vector (terminated by `in_last`) is emitted on a valid/ready output stream. It sits between the operand source and the multiplier, so the multiplier itself never sees handshakes.

## Interface
Parameters:
- `MULT_CYCLES`, default 6: number of multiplier compute edges after the load edge. Must equal the operand width.
- `ACC_W`, default 16: accumulator and `out_sum` width.

Ports:
- `clk`  in  1: single clock. All state changes on the rising edge.
- `rst`  in  1: synchronous, active-high reset. The multiplier's `rst` is tied to the same net at the top level.
- `in_valid`  in  1: operand pair present.
- `in_ready`  out  1: driver can accept a pair.
- `in_a`, `in_b`  in  6: unsigned operands.
- `in_last`  in  1: this pair closes the current vector.
- `mult_load`  out  1: one-cycle load pulse to the multiplier.
- `mult_a`, `mult_b`  out  6: registered operands to the multiplier.
- `mult_product`  in  13: multiplier product output.
- `out_valid`  out  1: vector result present.
- `out_ready`  in  1: consumer accepts the result.
- `out_sum`  out  ACC_W: sum of products for the vector, modulo 2^ACC_W.
- `out_ovf`  out  1: a carry out of ACC_W occurred at some point in the vector.
- `out_count`  out  5: pairs in the vector, saturating at 31.

## Operation
- FSM states and transitions:
  - IDLE → LOAD when `in_valid && in_ready`.
  - LOAD → WAIT.
  - WAIT → CAPT after MULT_CYCLES cycles.
  - CAPT → OUT if the latched `last` is set, else → IDLE.
  - OUT → IDLE when `out_ready`.
- `in_ready` = (state == IDLE). It is combinational from state only and never depends on `in_valid`.
- On accept, the driver latches `in_a`, `in_b` and `in_last`. `mult_a`/`mult_b` are driven from these latches and held stable from LOAD through CAPT.
- `mult_load` = 1 only in LOAD, for exactly one cycle per accepted pair.
- WAIT counter: 3 bits, cleared on entering WAIT, exits when the count reaches MULT_CYCLES−1.
- CAPT:
  - acc ← acc + zero-extended `mult_product`, computed at ACC_W+1 bits. The carry bit ORs into the sticky `ovf`.
  - count ← min(count+1, 31).
  - If `last` is set, `out_sum`/`out_ovf`/`out_count` are loaded from the post-add values.
- OUT:
  - `out_valid` = 1, and the outputs hold stable until the cycle with `out_ready` = 1.
  - On that handshake edge, acc, ovf and count clear to 0.
- A product of 0 (either operand 0) still counts as a pair.
- Reset values: state IDLE; acc, ovf, count = 0. All outputs are 0 during and after reset, except `in_ready`, which is 1 in the first cycle after reset deasserts.
- `rst` has priority in every state. Reset during LOAD/WAIT/CAPT discards the in-flight pair and the partial vector without producing output. The multiplier is reset by the same edge.

## Timing
- Accept edge at end of cycle c0 (IDLE).
- c1: LOAD, `mult_load` = 1. The multiplier clears its product on the c1 edge.
- c2–c7: WAIT, giving six multiplier compute edges.
- c8: CAPT, with `mult_product` final and stable.
- c9: OUT with `out_valid` = 1 for a last pair, or IDLE with `in_ready` = 1 otherwise.
- Fixed latency of 9 cycles from accept edge to `out_valid`, plus any `out_ready` stall.
- Maximum throughput is one pair per 9 cycles.
- `in_valid` held with `in_ready` = 0: no effect, and the pair stays pending at the source.
- OUT back-pressure blocks new accepts. There is no skid buffer.

## Test plan
- Single pair a=5, b=7, last=1:
  - `mult_load` pulses once, 1 cycle after accept.
  - `out_valid` rises exactly 9 cycles after the accept edge.
  - `out_sum` = 35, `out_count` = 1, `out_ovf` = 0.
- Vector (63,63), (1,2), (0,45) with last on the third pair:
  - `out_sum` = 3971, `out_count` = 3.
  - `in_ready` reasserts at cycle 9 after each non-last accept.
- Seventeen pairs of (63,63):
  - `out_sum` = 67473 mod 65536 = 1937, `out_ovf` = 1, `out_count` = 17.
  - The next vector (2,3) alone gives 6, `out_ovf` = 0, `out_count` = 1, confirming the clear on the handshake.
- Result with `out_ready` = 0 for 5 cycles:
  - `out_valid` and the outputs are held stable throughout.
  - `in_ready` stays 0 while `in_valid` = 1.
  - Accept occurs the cycle after the `out_ready` handshake.
- `rst` pulsed during the 3rd WAIT cycle of the second pair of a vector:
  - No `out_valid`, and the FSM is in IDLE with `in_ready` = 1 one cycle after `rst` deasserts.
  - A following (4,4,last) gives `out_sum` = 16, `out_count` = 1.
- Bench multiplier model must match the 6-bit shift-add timing: product cleared on the load edge, final after the 6th subsequent edge.

Source files
------------

// File: rtl/seq_mult_dot_driver.sv
// -----------------------------------------------------------------------------
// seq_mult_dot_driver
//
// Sequencing stage in front of a 6-bit unsigned sequential right-shift
// multiplier. Accepts operand pairs on a valid/ready stream, pulses the
// multiplier load, waits out the fixed compute time, captures the product,
// and accumulates products into a dot-product sum. One result per vector
// (closed by in_last) is presented on a valid/ready output stream.
//
// Ports:
//   clk          - clock, all state changes on the rising edge
//   rst          - synchronous active-high reset (shared with the multiplier)
//   in_valid     - operand pair present
//   in_ready     - driver can accept a pair (IDLE only)
//   in_a, in_b   - unsigned 6-bit operands
//   in_last      - pair closes the current vector
//   mult_load    - one-cycle load pulse to the multiplier
//   mult_a/b     - operands held stable to the multiplier from LOAD to CAPT
//   mult_product - 13-bit multiplier product
//   out_valid    - vector result present
//   out_ready    - consumer accepts the result
//   out_sum      - sum of products modulo 2^ACC_W
//   out_ovf      - sticky carry out of ACC_W seen during the vector
//   out_count    - pairs in the vector, saturating at 31
// -----------------------------------------------------------------------------
module seq_mult_dot_driver #(
    parameter int MULT_CYCLES = 6,
    parameter int ACC_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       in_a,
    input  logic [5:0]       in_b,
    input  logic             in_last,
    output logic             mult_load,
    output logic [5:0]       mult_a,
    output logic [5:0]       mult_b,
    input  logic [12:0]      mult_product,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf,
    output logic [4:0]       out_count
);

    localparam int         SUM_W     = ACC_W + 1;
    localparam logic [2:0] WAIT_LAST = 3'(MULT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_CAPT,
        S_OUT
    } state_t;

    state_t             r_state;
    logic [2:0]         r_wait_cnt;
    logic [5:0]         r_a;
    logic [5:0]         r_b;
    logic               r_last;
    logic               r_mult_load;
    logic [ACC_W-1:0]   r_acc;
    logic               r_ovf;
    logic [4:0]         r_count;
    logic               r_out_valid;
    logic [ACC_W-1:0]   r_out_sum;
    logic               r_out_ovf;
    logic [4:0]         r_out_count;

    logic [SUM_W-1:0]   w_sum;
    logic [4:0]         w_count_next;

    // Extra top bit of the add is the carry out of the accumulator width.
    assign w_sum        = {1'b0, r_acc} + SUM_W'(mult_product);
    assign w_count_next = (r_count == 5'd31) ? r_count : r_count + 5'd1;

    // Ready depends on state only, so the source never sees a comb loop.
    assign in_ready  = (r_state == S_IDLE);
    assign mult_load = r_mult_load;
    assign mult_a    = r_a;
    assign mult_b    = r_b;
    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_ovf   = r_out_ovf;
    assign out_count = r_out_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_wait_cnt  <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_last      <= 1'b0;
            r_mult_load <= 1'b0;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_ovf   <= 1'b0;
            r_out_count <= '0;
        end else begin
            r_mult_load <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        r_a         <= in_a;
                        r_b         <= in_b;
                        r_last      <= in_last;
                        r_mult_load <= 1'b1;
                        r_state     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_wait_cnt <= '0;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    // Counts 0..MULT_CYCLES-1: one WAIT cycle per compute edge.
                    if (r_wait_cnt == WAIT_LAST) begin
                        r_state <= S_CAPT;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 3'd1;
                    end
                end
                S_CAPT: begin
                    r_acc   <= w_sum[ACC_W-1:0];
                    r_ovf   <= r_ovf | w_sum[ACC_W];
                    r_count <= w_count_next;
                    if (r_last) begin
                        r_out_sum   <= w_sum[ACC_W-1:0];
                        r_out_ovf   <= r_ovf | w_sum[ACC_W];
                        r_out_count <= w_count_next;
                        r_out_valid <= 1'b1;
                        r_state     <= S_OUT;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_acc       <= '0;
                        r_ovf       <= 1'b0;
                        r_count     <= '0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult_dot_driver.sv
// -----------------------------------------------------------------------------
// tb_seq_mult_dot_driver
//
// Directed and randomized bench for seq_mult_dot_driver. A behavioural
// shift-add multiplier (product cleared on load, final after six compute
// edges) sits behind the driver. Expected results come from a plain
// arithmetic reference: running total of a*b per vector, reduced modulo
// 2^16, overflow when the total reaches 2^16, count saturating at 31.
// -----------------------------------------------------------------------------
module tb_seq_mult_dot_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_a;
    logic [5:0]  in_b;
    logic        in_last;
    logic        mult_load;
    logic [5:0]  mult_a;
    logic [5:0]  mult_b;
    logic [12:0] mult_product;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic        out_ovf;
    logic [4:0]  out_count;

    int errors = 0;
    int checks = 0;

    // Reference model state for the vector in progress.
    longint unsigned ref_total = 0;
    int              ref_n     = 0;

    always #5 clk = ~clk;

    seq_mult_dot_driver #(.MULT_CYCLES(6), .ACC_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_last      (in_last),
        .mult_load    (mult_load),
        .mult_a       (mult_a),
        .mult_b       (mult_b),
        .mult_product (mult_product),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sum      (out_sum),
        .out_ovf      (out_ovf),
        .out_count    (out_count)
    );

    // Behavioural 6-bit shift-add multiplier.
    logic [12:0] m_prod = '0;
    logic [5:0]  m_a    = '0;
    logic [5:0]  m_b    = '0;
    int          m_step = 6;

    assign mult_product = m_prod;

    always @(posedge clk) begin
        if (rst) begin
            m_prod <= '0;
            m_step <= 6;
        end else if (mult_load) begin
            m_prod <= '0;
            m_a    <= mult_a;
            m_b    <= mult_b;
            m_step <= 0;
        end else if (m_step < 6) begin
            if (m_b[m_step]) m_prod <= m_prod + (13'(m_a) << m_step);
            m_step <= m_step + 1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [22:0] ref_result();
        logic [15:0] s;
        logic        o;
        logic [4:0]  c;
        s = 16'(ref_total % 65536);
        o = (ref_total >= 65536);
        c = (ref_n > 31) ? 5'd31 : 5'(ref_n);
        return {1'b1, s, o, c};
    endfunction

    // Present a pair and wait (bounded) until it is seen with in_ready high.
    // Returns at the negedge just before the accepting edge; ok=0 on timeout.
    task automatic present(input logic [5:0] a, input logic [5:0] b, input logic last,
                           output bit ok);
        int k;
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        k = 0;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        ok = in_ready;
        if (!ok) chk("accept_timeout", {31'd0, in_ready}, 32'd1);
    endtask

    // Follow an accepted pair from c1 through c9, checking timing each cycle.
    task automatic track(input logic [5:0] a, input logic [5:0] b, input logic last);
        @(negedge clk);
        in_valid = 1'b0;
        ref_total += longint'(a) * longint'(b);
        ref_n++;
        chk("load_cycle", {mult_load, in_ready, out_valid, mult_a, mult_b},
            {3'b100, a, b});
        for (int k = 2; k <= 8; k++) begin
            @(negedge clk);
            chk("busy_cycle", {mult_load, in_ready, out_valid, mult_a, mult_b},
                {3'b000, a, b});
        end
        @(negedge clk);
        if (last) chk("c9_out_valid", {in_ready, out_valid, mult_load}, 3'b010);
        else      chk("c9_in_ready",  {in_ready, out_valid, mult_load}, 3'b100);
    endtask

    task automatic send(input logic [5:0] a, input logic [5:0] b, input logic last);
        bit ok;
        present(a, b, last, ok);
        if (ok) track(a, b, last);
    endtask

    // Called at the c9 negedge of a last pair: hold, then handshake.
    task automatic collect(input int stall);
        logic [22:0] exp;
        exp = ref_result();
        for (int k = 0; k < stall; k++) begin
            out_ready = 1'b0;
            chk("out_hold", {9'd0, out_valid, out_sum, out_ovf, out_count}, {9'd0, exp});
            @(negedge clk);
        end
        out_ready = 1'b1;
        chk("out_result", {9'd0, out_valid, out_sum, out_ovf, out_count}, {9'd0, exp});
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_handshake", {30'd0, out_valid, in_ready}, 32'd1);
        ref_total = 0;
        ref_n     = 0;
    endtask

    initial begin
        bit          ok;
        int          n;
        logic [5:0]  ra;
        logic [5:0]  rb;

        rst = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_last = 1'b0;
        out_ready = 1'b0;

        repeat (3) begin
            @(negedge clk);
            chk("reset_outputs",
                {8'd0, mult_load, out_valid, out_sum, out_ovf, out_count},
                32'd0);
            chk("reset_operands", {20'd0, mult_a, mult_b}, 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", {30'd0, in_ready, out_valid}, 32'd2);

        // Single pair 5*7.
        send(6'd5, 6'd7, 1'b1);
        chk("single_sum", {11'd0, out_sum, out_ovf, out_count}, {11'd0, 16'd35, 1'b0, 5'd1});
        collect(0);

        // Three-pair vector: 3969 + 2 + 0.
        send(6'd63, 6'd63, 1'b0);
        send(6'd1, 6'd2, 1'b0);
        send(6'd0, 6'd45, 1'b1);
        chk("dot3_sum", {11'd0, out_sum, out_ovf, out_count}, {11'd0, 16'd3971, 1'b0, 5'd3});
        collect(1);

        // Seventeen (63,63): 67473 wraps to 1937 with overflow.
        for (int i = 0; i < 17; i++) send(6'd63, 6'd63, (i == 16));
        chk("ovf_sum", {11'd0, out_sum, out_ovf, out_count}, {11'd0, 16'd1937, 1'b1, 5'd17});
        collect(0);
        send(6'd2, 6'd3, 1'b1);
        chk("after_ovf_clear", {11'd0, out_sum, out_ovf, out_count}, {11'd0, 16'd6, 1'b0, 5'd1});
        collect(0);

        // Back-pressure: result stalled 5 cycles while the next pair waits.
        send(6'd9, 6'd10, 1'b1);
        in_valid = 1'b1;
        in_a     = 6'd2;
        in_b     = 6'd3;
        in_last  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            out_ready = 1'b0;
            chk("stall_hold", {8'd0, out_valid, in_ready, out_sum, out_ovf, out_count},
                {8'd0, 1'b1, 1'b0, 16'd90, 1'b0, 5'd1});
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        ref_total = 0;
        ref_n     = 0;
        chk("stall_release", {29'd0, out_valid, in_ready, mult_load}, 32'd2);
        track(6'd2, 6'd3, 1'b1);
        chk("stall_next_sum", {11'd0, out_sum, out_ovf, out_count}, {11'd0, 16'd6, 1'b0, 5'd1});
        collect(0);

        // Reset in the 3rd WAIT cycle of the second pair.
        send(6'd20, 6'd30, 1'b0);
        present(6'd11, 6'd12, 1'b1, ok);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ref_total = 0;
        ref_n     = 0;
        chk("rst_mid_idle", {29'd0, in_ready, out_valid, mult_load}, 32'd4);
        @(negedge clk);
        chk("rst_mid_idle_next", {29'd0, in_ready, out_valid, mult_load}, 32'd4);
        send(6'd4, 6'd4, 1'b1);
        chk("rst_mid_result", {11'd0, out_sum, out_ovf, out_count}, {11'd0, 16'd16, 1'b0, 5'd1});
        collect(0);

        // Randomized vectors.
        for (int v = 0; v < 12; v++) begin
            n = (v == 11) ? 34 : int'($urandom_range(1, 6));
            for (int i = 0; i < n; i++) begin
                ra = 6'($urandom);
                rb = 6'($urandom);
                send(ra, rb, (i == n - 1));
            end
            collect(int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
